reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/rf_read_port.sv | 75 +++++++
 rtl/reg_file_sb.sv | 113 +++++++++++
 tb/tb_reg_file_sb.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU package: default datapath widths and helpers that locate a
// port's slice inside flattened multi-port buses.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

  // Default register width and register address width for the integer core.
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;

  // Default number of register-file read ports (two-operand ALU).
  localparam int NUM_RD_DEF = 2;

  // Lowest bit of port 'port' inside a bus built from 'width'-bit fields,
  // with port 0 in the least significant position.
  function automatic int port_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// -----------------------------------------------------------------------------
// rf_read_port
// One combinational read port of the scoreboarded register file. Selects
// between an immediate operand, the writeback value in flight (bypass), and
// the stored register, and reports whether the operand is still pending.
//
// Ports:
//   reset     in   forces rd_data/rd_busy to 0 while high
//   rd_addr   in   register index, or immediate value when rd_imm=1
//   rd_imm    in   immediate select
//   wr_en     in   writeback strobe (for bypass)
//   wr_addr   in   writeback destination
//   wr_data   in   writeback data
//   regs      in   full register storage from the top level
//   busy_vec  in   registered scoreboard state
//   rd_data   out  operand value
//   rd_busy   out  operand-not-ready flag
// -----------------------------------------------------------------------------
module rf_read_port
  import cpu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int ZERO_R0 = 0
) (
  input  logic                                reset,
  input  logic [ADDR_W-1:0]                   rd_addr,
  input  logic                                rd_imm,
  input  logic                                wr_en,
  input  logic [ADDR_W-1:0]                   wr_addr,
  input  logic [DATA_W-1:0]                   wr_data,
  input  logic [2**ADDR_W-1:0][DATA_W-1:0]    regs,
  input  logic [2**ADDR_W-1:0]                busy_vec,
  output logic [DATA_W-1:0]                   rd_data,
  output logic                                rd_busy
);

  localparam bit R0_HARD = (ZERO_R0 != 0);

  logic [DATA_W-1:0] imm_val;
  logic              wr_match;
  logic              addr_is_r0;

  // Immediate operands reuse the address field, zero-extended to DATA_W.
  always_comb begin
    imm_val = '0;
    imm_val[ADDR_W-1:0] = rd_addr;
  end

  assign wr_match   = wr_en && (wr_addr == rd_addr);
  assign addr_is_r0 = (rd_addr == '0);

  // Operand select. A hardwired r0 wins over the bypass so a discarded
  // write to r0 never leaks onto a read port. The same-cycle writeback
  // satisfies a pending operand, so it also clears the busy flag.
  always_comb begin
    rd_data = '0;
    rd_busy = 1'b0;
    if (!reset) begin
      if (rd_imm) begin
        rd_data = imm_val;
      end else begin
        rd_busy = busy_vec[rd_addr] && !wr_match;
        if (R0_HARD && addr_is_r0) begin
          rd_data = '0;
        end else if (wr_match) begin
          rd_data = wr_data;
        end else begin
          rd_data = regs[rd_addr];
        end
      end
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
// Register file with an issue/writeback scoreboard. Issue marks a destination
// busy, writeback stores the data and clears it; a second issue to a
// still-busy register raises a sticky write-after-write error.
//
// Ports:
//   clk         in   clock, all state changes on the rising edge
//   reset       in   synchronous active-high reset
//   wr_en       in   writeback strobe
//   wr_addr     in   writeback destination
//   wr_data     in   writeback data
//   issue_en    in   marks issue_addr busy
//   issue_addr  in   destination being issued
//   rd_addr     in   per-port read address, port k at [k*ADDR_W +: ADDR_W]
//   rd_imm      in   per-port immediate select
//   rd_data     out  per-port read data, port k at [k*DATA_W +: DATA_W]
//   rd_busy     out  per-port operand-not-ready flag
//   busy_vec    out  registered scoreboard state, one bit per register
//   err_waw     out  sticky write-after-write hazard flag
// -----------------------------------------------------------------------------
module reg_file_sb
  import cpu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_RD  = NUM_RD_DEF,
  parameter int ZERO_R0 = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      issue_en,
  input  logic [ADDR_W-1:0]         issue_addr,
  input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
  input  logic [NUM_RD-1:0]         rd_imm,
  output logic [NUM_RD*DATA_W-1:0]  rd_data,
  output logic [NUM_RD-1:0]         rd_busy,
  output logic [2**ADDR_W-1:0]      busy_vec,
  output logic                      err_waw
);

  localparam int DEPTH   = 2**ADDR_W;
  localparam bit R0_HARD = (ZERO_R0 != 0);

  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic [DEPTH-1:0]             busy_next;
  logic                         wr_ok;
  logic                         issue_ok;
  logic                         waw_hit;

  // With a hardwired r0, writes and issues to address 0 are simply dropped.
  assign wr_ok    = wr_en    && !(R0_HARD && (wr_addr    == '0));
  assign issue_ok = issue_en && !(R0_HARD && (issue_addr == '0));

  // Next scoreboard state: clear on writeback first, then set on issue, so
  // a same-address issue and writeback in one cycle leaves the bit set.
  always_comb begin
    busy_next = busy_vec;
    if (wr_en) begin
      busy_next[wr_addr] = 1'b0;
    end
    if (issue_ok) begin
      busy_next[issue_addr] = 1'b1;
    end
  end

  // Re-issuing a busy destination is a hazard unless the pending result is
  // retired in the same cycle.
  assign waw_hit = issue_ok && busy_vec[issue_addr] &&
                   !(wr_en && (wr_addr == issue_addr));

  // Storage, scoreboard and error flag. Reset wins over any write or issue
  // presented in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs     <= '0;
      busy_vec <= '0;
      err_waw  <= 1'b0;
    end else begin
      if (wr_ok) begin
        regs[wr_addr] <= wr_data;
      end
      busy_vec <= busy_next;
      if (waw_hit) begin
        err_waw <= 1'b1;
      end
    end
  end

  // One read port per operand slot.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    rf_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_R0 (ZERO_R0)
    ) u_port (
      .reset    (reset),
      .rd_addr  (rd_addr[port_lo(k, ADDR_W) +: ADDR_W]),
      .rd_imm   (rd_imm[k]),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .regs     (regs),
      .busy_vec (busy_vec),
      .rd_data  (rd_data[port_lo(k, DATA_W) +: DATA_W]),
      .rd_busy  (rd_busy[k])
    );
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// -----------------------------------------------------------------------------
// tb_reg_file_sb
// Directed bench for reg_file_sb. Two instances share the stimulus: dut_a with
// a writable r0 and dut_b with a hardwired-zero r0.
// -----------------------------------------------------------------------------
module tb_reg_file_sb;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        issue_en;
  logic [3:0]  issue_addr;
  logic [7:0]  rd_addr;
  logic [1:0]  rd_imm;

  logic [31:0] rd_data_a;
  logic [1:0]  rd_busy_a;
  logic [15:0] busy_vec_a;
  logic        err_waw_a;

  logic [31:0] rd_data_b;
  logic [1:0]  rd_busy_b;
  logic [15:0] busy_vec_b;
  logic        err_waw_b;

  int checks = 0;
  int errors = 0;

  reg_file_sb #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2), .ZERO_R0(0)) dut_a (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .rd_addr    (rd_addr),
    .rd_imm     (rd_imm),
    .rd_data    (rd_data_a),
    .rd_busy    (rd_busy_a),
    .busy_vec   (busy_vec_a),
    .err_waw    (err_waw_a)
  );

  reg_file_sb #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2), .ZERO_R0(1)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .rd_addr    (rd_addr),
    .rd_imm     (rd_imm),
    .rd_data    (rd_data_b),
    .rd_busy    (rd_busy_b),
    .busy_vec   (busy_vec_b),
    .err_waw    (err_waw_b)
  );

  // 10 time-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle's inputs, then let combinational outputs settle.
  task automatic applyStimulus(input logic we, input logic [3:0] wa,
                               input logic [15:0] wd, input logic ie,
                               input logic [3:0] ia, input logic [3:0] ra0,
                               input logic [3:0] ra1, input logic [1:0] imm);
    wr_en      = we;
    wr_addr    = wa;
    wr_data    = wd;
    issue_en   = ie;
    issue_addr = ia;
    rd_addr    = {ra1, ra0};
    rd_imm     = imm;
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(0, 4'h0, 16'h0000, 0, 4'h0, 4'h0, 4'h0, 2'b00);
    tick();
    tick();
    reset = 1'b0;
    applyStimulus(0, 4'h0, 16'h0000, 0, 4'h0, 4'h0, 4'h0, 2'b00);
    $display("[TB] reset state");
    checkOutput("init_busy_vec", 32'(busy_vec_a), 32'h0000);
    checkOutput("init_err_waw", 32'(err_waw_a), 32'h0);
    checkOutput("init_rd0", 32'(rd_data_a[15:0]), 32'h0000);

    // Populate a couple of registers and leave r9 busy.
    applyStimulus(1, 4'h2, 16'h1111, 1, 4'h9, 4'h2, 4'h5, 2'b00);
    tick();
    applyStimulus(1, 4'h5, 16'h2222, 0, 4'h0, 4'h2, 4'h5, 2'b00);
    tick();
    applyStimulus(0, 4'h0, 16'h0000, 0, 4'h0, 4'h2, 4'h5, 2'b00);
    checkOutput("pre_rd_r2", 32'(rd_data_a[15:0]), 32'h1111);
    checkOutput("pre_rd_r5", 32'(rd_data_a[31:16]), 32'h2222);
    checkOutput("pre_busy_vec", 32'(busy_vec_a), 32'h0200);

    // Reset for two cycles with a write and issue pending; outputs forced low.
    $display("[TB] reset override");
    reset = 1'b1;
    applyStimulus(1, 4'h2, 16'hDEAD, 1, 4'h4, 4'h2, 4'h9, 2'b00);
    checkOutput("rst_rd0_forced", 32'(rd_data_a[15:0]), 32'h0000);
    checkOutput("rst_rbusy1_forced", 32'(rd_busy_a[1]), 32'h0);
    tick();
    tick();
    reset = 1'b0;
    applyStimulus(0, 4'h0, 16'h0000, 0, 4'h0, 4'h2, 4'h5, 2'b00);
    checkOutput("rst_rd_r2", 32'(rd_data_a[15:0]), 32'h0000);
    checkOutput("rst_rd_r5", 32'(rd_data_a[31:16]), 32'h0000);
    checkOutput("rst_busy_vec", 32'(busy_vec_a), 32'h0000);
    checkOutput("rst_err_waw", 32'(err_waw_a), 32'h0);

    // Bypass: r5 pending, writeback satisfies the read in the same cycle.
    $display("[TB] bypass");
    applyStimulus(0, 4'h0, 16'h0000, 1, 4'h5, 4'h5, 4'h0, 2'b00);
    tick();
    applyStimulus(0, 4'h0, 16'h0000, 0, 4'h0, 4'h5, 4'h0, 2'b00);
    checkOutput("byp_pending_busy", 32'(rd_busy_a[0]), 32'h1);
    checkOutput("byp_busy_vec", 32'(busy_vec_a), 32'h0020);
    applyStimulus(1, 4'h5, 16'hBEEF, 0, 4'h0, 4'h5, 4'h0, 2'b00);
    checkOutput("byp_rd0", 32'(rd_data_a[15:0]), 32'hBEEF);
    checkOutput("byp_rbusy0", 32'(rd_busy_a[0]), 32'h0);
    tick();
    applyStimulus(0, 4'h0, 16'h0000, 0, 4'h0, 4'h5, 4'h0, 2'b00);
    checkOutput("byp_stored", 32'(rd_data_a[15:0]), 32'hBEEF);
    checkOutput("byp_cleared", 32'(busy_vec_a), 32'h0000);

    // Same-cycle issue+writeback to r10 (set wins), then immediate reads.
    $display("[TB] immediate");
    applyStimulus(1, 4'hA, 16'h5555, 1, 4'hA, 4'hA, 4'hA, 2'b10);
    checkOutput("imm_rd1_comb", 32'(rd_data_a[31:16]), 32'h000A);
    checkOutput("imm_rd0_bypass", 32'(rd_data_a[15:0]), 32'h5555);
    tick();
    applyStimulus(0, 4'h0, 16'h0000, 0, 4'h0, 4'hA, 4'hA, 2'b10);
    checkOutput("setwins_busy_vec", 32'(busy_vec_a), 32'h0400);
    checkOutput("setwins_err", 32'(err_waw_a), 32'h0);
    checkOutput("imm_rd1", 32'(rd_data_a[31:16]), 32'h000A);
    checkOutput("imm_rbusy1", 32'(rd_busy_a[1]), 32'h0);
    checkOutput("reg_rd0_r10", 32'(rd_data_a[15:0]), 32'h5555);
    checkOutput("reg_rbusy0_r10", 32'(rd_busy_a[0]), 32'h1);
    applyStimulus(0, 4'h0, 16'h0000, 0, 4'h0, 4'hA, 4'hA, 2'b00);
    checkOutput("same_rd1_r10", 32'(rd_data_a[31:16]), 32'h5555);
    checkOutput("same_rbusy1_r10", 32'(rd_busy_a[1]), 32'h1);
    applyStimulus(1, 4'hA, 16'h5555, 0, 4'h0, 4'h0, 4'h0, 2'b00);
    tick();
    applyStimulus(0, 4'h0, 16'h0000, 0, 4'h0, 4'h0, 4'h0, 2'b00);
    checkOutput("imm_cleanup_busy", 32'(busy_vec_a), 32'h0000);

    // Scoreboard round trip on r3, both ports reading it.
    $display("[TB] scoreboard");
    applyStimulus(0, 4'h0, 16'h0000, 1, 4'h3, 4'h0, 4'h0, 2'b00);
    tick();
    applyStimulus(0, 4'h0, 16'h0000, 0, 4'h0, 4'h3, 4'h3, 2'b00);
    checkOutput("sb_rbusy0", 32'(rd_busy_a[0]), 32'h1);
    checkOutput("sb_rbusy1", 32'(rd_busy_a[1]), 32'h1);
    checkOutput("sb_busy_vec", 32'(busy_vec_a), 32'h0008);
    applyStimulus(1, 4'h3, 16'h1234, 0, 4'h0, 4'h3, 4'h3, 2'b00);
    tick();
    applyStimulus(0, 4'h0, 16'h0000, 0, 4'h0, 4'h3, 4'h3, 2'b00);
    checkOutput("sb_cleared", 32'(busy_vec_a), 32'h0000);
    checkOutput("sb_rd0", 32'(rd_data_a[15:0]), 32'h1234);
    checkOutput("sb_rd1", 32'(rd_data_a[31:16]), 32'h1234);
    checkOutput("sb_rbusy0_done", 32'(rd_busy_a[0]), 32'h0);

    // Issue r8 while writing non-busy r3: both take effect, no error.
    applyStimulus(1, 4'h3, 16'h4321, 1, 4'h8, 4'h0, 4'h0, 2'b00);
    tick();
    applyStimulus(0, 4'h0, 16'h0000, 0, 4'h0, 4'h3, 4'h0, 2'b00);
    checkOutput("diff_busy_vec", 32'(busy_vec_a), 32'h0100);
    checkOutput("diff_err", 32'(err_waw_a), 32'h0);
    checkOutput("diff_rd_r3", 32'(rd_data_a[15:0]), 32'h4321);

    // Hazards on r7.
    $display("[TB] hazards");
    applyStimulus(0, 4'h0, 16'h0000, 1, 4'h7, 4'h0, 4'h0, 2'b00);
    tick();
    applyStimulus(1, 4'h7, 16'h7777, 1, 4'h7, 4'h0, 4'h0, 2'b00);
    tick();
    applyStimulus(0, 4'h0, 16'h0000, 0, 4'h0, 4'h7, 4'h0, 2'b00);
    checkOutput("haz_setwins_vec", 32'(busy_vec_a), 32'h0180);
    checkOutput("haz_noerr", 32'(err_waw_a), 32'h0);
    checkOutput("haz_rd_r7", 32'(rd_data_a[15:0]), 32'h7777);
    applyStimulus(0, 4'h0, 16'h0000, 1, 4'h7, 4'h0, 4'h0, 2'b00);
    tick();
    applyStimulus(0, 4'h0, 16'h0000, 0, 4'h0, 4'h0, 4'h0, 2'b00);
    checkOutput("haz_waw_set", 32'(err_waw_a), 32'h1);
    checkOutput("haz_busy_vec", 32'(busy_vec_a), 32'h0180);
    tick();
    checkOutput("haz_sticky", 32'(err_waw_a), 32'h1);

    // Hardwired r0 (dut_b) against writable r0 (dut_a).
    $display("[TB] zero r0");
    reset = 1'b1;
    applyStimulus(0, 4'h0, 16'h0000, 0, 4'h0, 4'h0, 4'h0, 2'b00);
    tick();
    tick();
    reset = 1'b0;
    applyStimulus(1, 4'h0, 16'hFFFF, 0, 4'h0, 4'h0, 4'h0, 2'b00);
    checkOutput("z_b_bypass_r0", 32'(rd_data_b[15:0]), 32'h0000);
    checkOutput("z_a_bypass_r0", 32'(rd_data_a[15:0]), 32'hFFFF);
    tick();
    applyStimulus(0, 4'h0, 16'h0000, 1, 4'h0, 4'h0, 4'h0, 2'b00);
    checkOutput("z_b_rd_r0", 32'(rd_data_b[15:0]), 32'h0000);
    checkOutput("z_a_rd_r0", 32'(rd_data_a[15:0]), 32'hFFFF);
    tick();
    applyStimulus(0, 4'h0, 16'h0000, 1, 4'h0, 4'h0, 4'h0, 2'b00);
    tick();
    applyStimulus(0, 4'h0, 16'h0000, 0, 4'h0, 4'h0, 4'h0, 2'b00);
    checkOutput("z_b_rd_final", 32'(rd_data_b[15:0]), 32'h0000);
    checkOutput("z_b_busy_vec", 32'(busy_vec_b), 32'h0000);
    checkOutput("z_b_err", 32'(err_waw_b), 32'h0);
    checkOutput("z_b_rbusy0", 32'(rd_busy_b[0]), 32'h0);
    checkOutput("z_a_busy_vec", 32'(busy_vec_a), 32'h0001);
    checkOutput("z_a_err", 32'(err_waw_a), 32'h1);
    checkOutput("z_a_rbusy0", 32'(rd_busy_a[0]), 32'h1);

    // Reset clears the sticky error and the scoreboard.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checkOutput("end_err_cleared", 32'(err_waw_a), 32'h0);
    checkOutput("end_busy_cleared", 32'(busy_vec_a), 32'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
